// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the RV32I(+M) decode stage.
// Holds opcode and funct7 constants, the ALU operation encodings, the
// writeback result-source encodings, the registered control-bundle struct
// and the funct3 -> ALU operation helper shared by R-type and I-type ALU decode.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_MUL   = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    result_src_t result_src;
    logic        branch;
    logic        jump;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        lui;
    alu_op_t     alu_op;
  } ctrl_bundle_t;

  // Common funct3 map for register and immediate ALU ops; SUB is chosen by
  // the caller because only R-type may select it.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3,
                                              input logic       arith_shift);
    alu_op_t op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = arith_shift ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: purely combinational RV32I(+optional MUL) decoder.
// Ports:
//   instr   in  32  instruction word
//   bundle  out     decoded control bundle (all zero when illegal)
//   illegal out 1   instruction is not in the supported set
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t bundle,
  output logic         illegal
);

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic         unused_fields;
  ctrl_bundle_t dec;
  logic         ill;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec = '0;
    ill = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b0;
        if (funct7 == F7_BASE) begin
          dec.alu_op = alu_from_funct3(funct3, 1'b0);
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      dec.alu_op = ALU_SUB;
          else if (funct3 == 3'b101) dec.alu_op = ALU_SRA;
          else                       ill = 1'b1;
        end else if (funct7 == F7_MULDIV && ENABLE_M && funct3 == 3'b000) begin
          dec.alu_op = ALU_MUL;
        end else begin
          ill = 1'b1;
        end
      end
      OP_IALU: begin
        dec.reg_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_op    = alu_from_funct3(funct3, funct7[5]);
        // Shift immediates carry a function code in imm[11:5].
        if ((funct3 == 3'b001 || funct3 == 3'b101) &&
            funct7 != F7_BASE && funct7 != F7_ALT)
          ill = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.result_src = RES_MEM;
        dec.alu_op     = ALU_ADD;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) ill = 1'b1;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_op    = ALU_ADD;
        if (funct3 > 3'b010) ill = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch    = 1'b1;
        dec.alu_src_b = 1'b0;
        dec.alu_op    = ALU_SUB;
        if (funct3 == 3'b010 || funct3 == 3'b011) ill = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.lui       = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_op    = ALU_PASSB;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = RES_PC4;
        dec.alu_src_a  = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.alu_op     = ALU_ADD;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = RES_PC4;
        dec.alu_src_b  = 1'b1;
        dec.alu_op     = ALU_ADD;
        if (funct3 != 3'b000) ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // Illegal instructions must not enable anything downstream.
    if (ill) dec = '0;
  end

  assign bundle  = dec;
  assign illegal = ill;

endmodule

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: decode stage between the IF/ID register and execute.
// Decodes instr_d and registers the control bundle into the ID/EX boundary
// behind a valid/ready handshake, with flush and an illegal-instruction count.
// Ports:
//   clk, rst (async, active-low)
//   instr_d/in_valid/in_ready    upstream handshake
//   flush                        kills the registered bundle and any offer
//   out_valid/out_ready          downstream handshake
//   reg_write_e .. alu_ctrl_e    registered control bundle
//   illegal_e                    registered bundle came from an illegal word
//   ill_count                    saturating count of accepted illegal words
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M  = 1'b0,
  parameter int ALUC_W    = 4,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr_d,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 reg_write_e,
  output logic                 mem_write_e,
  output logic [1:0]           result_src_e,
  output logic                 branch_e,
  output logic                 jump_e,
  output logic                 alu_src_a_e,
  output logic                 alu_src_b_e,
  output logic                 lui_e,
  output logic [ALUC_W-1:0]    alu_ctrl_e,
  output logic                 illegal_e,
  output logic [ILL_CNT_W-1:0] ill_count
);

  if (ALUC_W < 4) begin : g_bad_aluc_w
    $error("ALUC_W must be at least 4");
  end

  function automatic logic [ILL_CNT_W-1:0] sat_inc(input logic [ILL_CNT_W-1:0] v);
    return (v == '1) ? v : v + ILL_CNT_W'(1);
  endfunction

  ctrl_bundle_t          bundle_p0;
  logic                  illegal_p0;
  ctrl_bundle_t          bundle_p1;
  logic                  illegal_p1;
  logic                  vld_p1;
  logic [ILL_CNT_W-1:0]  ill_cnt_p1;
  logic                  take_p0;
  logic [3:0]            alu_code_p1;

  // ---- p0: combinational decode of the IF/ID word ----
  ctrl_decode_comb #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .instr   (instr_d),
    .bundle  (bundle_p0),
    .illegal (illegal_p0)
  );

  // Flush still reports ready so upstream treats the dropped word as consumed.
  assign in_ready = !vld_p1 || out_ready;
  assign take_p0  = in_valid && in_ready && !flush;

  // ---- p0 -> p1: ID/EX boundary register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      bundle_p1  <= '0;
      illegal_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1     <= 1'b0;
      bundle_p1  <= '0;
      illegal_p1 <= 1'b0;
    end else if (in_ready) begin
      // Taking a word or emitting a bubble; holding is the implicit else.
      vld_p1     <= in_valid;
      bundle_p1  <= in_valid ? bundle_p0 : '0;
      illegal_p1 <= in_valid && illegal_p0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ill_cnt_p1 <= '0;
    end else if (take_p0 && illegal_p0) begin
      ill_cnt_p1 <= sat_inc(ill_cnt_p1);
    end
  end

  // ---- p1: drive the execute-stage outputs ----
  assign alu_code_p1  = bundle_p1.alu_op;
  assign out_valid    = vld_p1;
  assign reg_write_e  = bundle_p1.reg_write;
  assign mem_write_e  = bundle_p1.mem_write;
  assign result_src_e = bundle_p1.result_src;
  assign branch_e     = bundle_p1.branch;
  assign jump_e       = bundle_p1.jump;
  assign alu_src_a_e  = bundle_p1.alu_src_a;
  assign alu_src_b_e  = bundle_p1.alu_src_b;
  assign lui_e        = bundle_p1.lui;
  assign alu_ctrl_e   = ALUC_W'(alu_code_p1);
  assign illegal_e    = illegal_p1;
  assign ill_count    = ill_cnt_p1;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: one instance without M (ALUC_W=4)
// and one with M (ALUC_W=5) see identical stimulus; each has its own queue.
module tb_ctrl_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic        in_valid, flush, out_ready;

  logic       in_ready0, ov0, rw0, mw0, br0, j0, sa0, sb_0, lui0, ill0;
  logic [1:0] rs0;
  logic [3:0] alu0;
  logic [7:0] cnt0_out;
  logic       in_ready1, ov1, rw1, mw1, br1, j1, sa1, sb_1, lui1, ill1;
  logic [1:0] rs1;
  logic [4:0] alu1;
  logic [7:0] cnt1_out;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.ENABLE_M(1'b0), .ALUC_W(4), .ILL_CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .instr_d(instr_d), .in_valid(in_valid), .in_ready(in_ready0),
    .flush(flush), .out_valid(ov0), .out_ready(out_ready), .reg_write_e(rw0),
    .mem_write_e(mw0), .result_src_e(rs0), .branch_e(br0), .jump_e(j0),
    .alu_src_a_e(sa0), .alu_src_b_e(sb_0), .lui_e(lui0), .alu_ctrl_e(alu0),
    .illegal_e(ill0), .ill_count(cnt0_out));

  ctrl_decode_stage #(.ENABLE_M(1'b1), .ALUC_W(5), .ILL_CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .instr_d(instr_d), .in_valid(in_valid), .in_ready(in_ready1),
    .flush(flush), .out_valid(ov1), .out_ready(out_ready), .reg_write_e(rw1),
    .mem_write_e(mw1), .result_src_e(rs1), .branch_e(br1), .jump_e(j1),
    .alu_src_a_e(sa1), .alu_src_b_e(sb_1), .lui_e(lui1), .alu_ctrl_e(alu1),
    .illegal_e(ill1), .ill_count(cnt1_out));

  typedef struct {
    logic [13:0] e;
    int          cnt;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [13:0] e0;
    logic [13:0] e1;
  } vec_t;

  exp_t sbq0[$];
  exp_t sbq1[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt0 = 0;
  int   cnt1 = 0;

  logic [13:0] act0, act1;
  assign act0 = {rw0, mw0, rs0, br0, j0, sa0, sb_0, lui0, alu0, ill0};
  assign act1 = {rw1, mw1, rs1, br1, j1, sa1, sb_1, lui1, alu1[3:0], ill1};

  localparam logic [13:0] ILL = 14'h0001;

  function automatic logic [13:0] mk(input logic rw, input logic mw, input logic [1:0] rs,
                                     input logic br, input logic j, input logic sa,
                                     input logic sb, input logic lu, input logic [3:0] alu,
                                     input logic ill);
    return {rw, mw, rs, br, j, sa, sb, lu, alu, ill};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: the front entry must be on the outputs while out_valid is high;
  // it retires when out_ready accepts it. With out_valid low all fields are 0.
  always @(negedge clk) begin
    if (ov0) begin
      if (sbq0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_out0: got bundle %h expected none at %0t", act0, $time);
      end else begin
        chk("bundle0", 32'(act0), 32'(sbq0[0].e));
        chk("ill_count0", 32'(cnt0_out), sbq0[0].cnt);
        if (out_ready) void'(sbq0.pop_front());
      end
    end else begin
      chk("idle0", 32'(act0), 32'd0);
    end
    if (ov1) begin
      if (sbq1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_out1: got bundle %h expected none at %0t", act1, $time);
      end else begin
        chk("bundle1", 32'({alu1[4], act1}), 32'({1'b0, sbq1[0].e}));
        chk("ill_count1", 32'(cnt1_out), sbq1[0].cnt);
        if (out_ready) void'(sbq1.pop_front());
      end
    end else begin
      chk("idle1", 32'({alu1[4], act1}), 32'd0);
    end
  end

  // Offer one word; record expectations at the edge where it is taken.
  task automatic send(input logic [31:0] ins, input logic [13:0] e0, input logic [13:0] e1);
    exp_t x;
    int   n = 0;
    instr_d  = ins;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for %h", ins);
    end else begin
      if (e0[0] && cnt0 < 255) cnt0++;
      if (e1[0] && cnt1 < 255) cnt1++;
      x.e = e0; x.cnt = cnt0; sbq0.push_back(x);
      x.e = e1; x.cnt = cnt1; sbq1.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] mul1;
    mul1 = mk(1,0,2'd0,0,0,0,0,0,4'd11,0);
    vecs.push_back('{32'h002081B3, mk(1,0,2'd0,0,0,0,0,0,4'd0,0),  mk(1,0,2'd0,0,0,0,0,0,4'd0,0)});
    vecs.push_back('{32'h402081B3, mk(1,0,2'd0,0,0,0,0,0,4'd1,0),  mk(1,0,2'd0,0,0,0,0,0,4'd1,0)});
    vecs.push_back('{32'h0040A283, mk(1,0,2'd1,0,0,0,1,0,4'd0,0),  mk(1,0,2'd1,0,0,0,1,0,4'd0,0)});
    vecs.push_back('{32'h0050A423, mk(0,1,2'd0,0,0,0,1,0,4'd0,0),  mk(0,1,2'd0,0,0,0,1,0,4'd0,0)});
    vecs.push_back('{32'h123450B7, mk(1,0,2'd0,0,0,0,1,1,4'd10,0), mk(1,0,2'd0,0,0,0,1,1,4'd10,0)});
    vecs.push_back('{32'h008000EF, mk(1,0,2'd2,0,1,1,1,0,4'd0,0),  mk(1,0,2'd2,0,1,1,1,0,4'd0,0)});
    vecs.push_back('{32'h00008067, mk(1,0,2'd2,0,1,0,1,0,4'd0,0),  mk(1,0,2'd2,0,1,0,1,0,4'd0,0)});
    vecs.push_back('{32'h00001097, mk(1,0,2'd0,0,0,1,1,0,4'd0,0),  mk(1,0,2'd0,0,0,1,1,0,4'd0,0)});
    vecs.push_back('{32'h00208063, mk(0,0,2'd0,1,0,0,0,0,4'd1,0),  mk(0,0,2'd0,1,0,0,0,0,4'd1,0)});
    vecs.push_back('{32'h00000013, mk(1,0,2'd0,0,0,0,1,0,4'd0,0),  mk(1,0,2'd0,0,0,0,1,0,4'd0,0)});
    vecs.push_back('{32'h4030D093, mk(1,0,2'd0,0,0,0,1,0,4'd9,0),  mk(1,0,2'd0,0,0,0,1,0,4'd9,0)});
    vecs.push_back('{32'h4020D1B3, mk(1,0,2'd0,0,0,0,0,0,4'd9,0),  mk(1,0,2'd0,0,0,0,0,0,4'd9,0)});
    vecs.push_back('{32'h0020F1B3, mk(1,0,2'd0,0,0,0,0,0,4'd2,0),  mk(1,0,2'd0,0,0,0,0,0,4'd2,0)});
    vecs.push_back('{32'h0050B093, mk(1,0,2'd0,0,0,0,1,0,4'd6,0),  mk(1,0,2'd0,0,0,0,1,0,4'd6,0)});
    vecs.push_back('{32'h022081B3, ILL, mul1});
    vecs.push_back('{32'h022091B3, ILL, ILL});
    vecs.push_back('{32'h00000000, ILL, ILL});
    vecs.push_back('{32'h0020A063, ILL, ILL});
    vecs.push_back('{32'h02309093, ILL, ILL});
    vecs.push_back('{32'h4020F1B3, ILL, ILL});
    vecs.push_back('{32'h00009067, ILL, ILL});
    vecs.push_back('{32'h0040B283, ILL, ILL});
    vecs.push_back('{32'h0050B423, ILL, ILL});

    rst = 1'b0; instr_d = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(ov0), 32'd0);
    chk("reset_ill_count", 32'(cnt0_out), 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready0), 32'd1);
    @(posedge clk); #1;

    // Directed decode vectors, back to back
    foreach (vecs[i]) send(vecs[i].ins, vecs[i].e0, vecs[i].e1);
    drain();

    // Backpressure: lw held while sw waits
    out_ready = 1'b0;
    send(32'h0040A283, mk(1,0,2'd1,0,0,0,1,0,4'd0,0), mk(1,0,2'd1,0,0,0,1,0,4'd0,0));
    instr_d = 32'h0050A423; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("in_ready_stall", 32'(in_ready0), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h0050A423, mk(0,1,2'd0,0,0,0,1,0,4'd0,0), mk(0,1,2'd0,0,0,0,1,0,4'd0,0));
    drain();

    // Flush with a simultaneous valid offer: dropped, yet ready
    flush = 1'b1; instr_d = 32'h002081B3; in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_flush", 32'(in_ready0), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("out_valid_after_flush", 32'(ov0), 32'd0);
    @(posedge clk); #1;

    // Flush kills a bundle being held by backpressure
    out_ready = 1'b0;
    send(32'h0020F1B3, mk(1,0,2'd0,0,0,0,0,0,4'd2,0), mk(1,0,2'd0,0,0,0,0,0,4'd2,0));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    void'(sbq0.pop_front());
    void'(sbq1.pop_front());
    @(negedge clk);
    chk("held_flushed", 32'(ov0), 32'd0);
    drain();

    // Saturating illegal counter
    for (int k = 0; k < 300; k++)
      send(32'h022081B3, ILL, mul1);
    drain();
    chk("ill_count_saturated", 32'(cnt0_out), 32'd255);
    chk("ill_count_m", 32'(cnt1_out), 32'd8);

    // Asynchronous reset while a bundle is held
    out_ready = 1'b0;
    send(32'h123450B7, mk(1,0,2'd0,0,0,0,1,1,4'd10,0), mk(1,0,2'd0,0,0,0,1,1,4'd10,0));
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ov0), 32'd0);
    chk("async_rst_fields", 32'(act0), 32'd0);
    chk("async_rst_count", 32'(cnt0_out), 32'd0);
    sbq0.delete(); sbq1.delete();
    cnt0 = 0; cnt1 = 0;
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("ready_after_async_rst", 32'(in_ready0), 32'd1);

    drain();
    chk("sb0_empty", sbq0.size(), 32'd0);
    chk("sb1_empty", sbq1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
